// File: rtl/bsg_mem_1rw_sync_mask_write_bit_init.sv
// Single-port synchronous bit-mask RAM with a post-reset init sweep, valid/ready request side and valid/yumi held response.
// Optional simulation checks are enabled by defining BSG_MEM_1RW_INIT_ASSERT_EN.

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

module bsg_mem_1rw_sync_mask_write_bit_init #(
    parameter int                 width_p       = 8,
    parameter int                 els_p         = 16,
    parameter logic [width_p-1:0] init_val_p    = '0,
    parameter int                 addr_width_lp = `BSG_SAFE_CLOG2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    input  logic                     yumi_i,
    output logic                     init_done_o
);

    typedef enum logic [1:0] {INIT, RUN, HOLD} state_e;

    localparam logic [addr_width_lp-1:0] cnt_last_lp = addr_width_lp'(els_p - 1);

    state_e                   state_r, state_n;
    logic [addr_width_lp-1:0] cnt_r;
    logic                     init_done_r;
    logic [width_p-1:0]       data_r;
    logic [width_p-1:0]       mem_r [els_p];

    logic                     accept;
    logic                     mem_en, mem_w, mem_valid;
    logic [addr_width_lp-1:0] mem_addr;
    logic [width_p-1:0]       mem_wdata, mem_wmask;

    always_comb begin
        state_n = state_r;
        ready_o = 1'b0;
        case (state_r)
            INIT: if (cnt_r == cnt_last_lp) state_n = RUN;
            RUN: begin
                ready_o = 1'b1;
                if (v_i & ~w_i) state_n = HOLD;
            end
            HOLD: begin
                // consumer pop frees the output register for a same-cycle read
                ready_o = yumi_i;
                if (yumi_i) state_n = (v_i & ~w_i) ? HOLD : RUN;
            end
            default: state_n = INIT;
        endcase
    end

    assign accept = v_i & ready_o;

    // The sweep owns the single port; otherwise an accepted request drives it.
    always_comb begin
        mem_en    = 1'b0;
        mem_w     = 1'b0;
        mem_addr  = addr_i;
        mem_wdata = data_i;
        mem_wmask = w_mask_i;
        if (state_r == INIT) begin
            mem_en    = 1'b1;
            mem_w     = 1'b1;
            mem_addr  = cnt_r;
            mem_wdata = init_val_p;
            mem_wmask = '1;
        end else if (accept) begin
            mem_en = 1'b1;
            mem_w  = w_i;
        end
    end

    assign mem_valid = (32'(mem_addr) < els_p);

    always_ff @(posedge clk_i) begin
        if (mem_en & mem_w & mem_valid)
            mem_r[mem_addr] <= (mem_r[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= INIT;
            cnt_r       <= '0;
            init_done_r <= 1'b0;
            data_r      <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == INIT && cnt_r != cnt_last_lp)
                cnt_r <= cnt_r + 1'b1;
            if (state_r == INIT && cnt_r == cnt_last_lp)
                init_done_r <= 1'b1;
            if (mem_en & ~mem_w)
                data_r <= mem_valid ? mem_r[mem_addr] : init_val_p;
        end
    end

    assign v_o         = (state_r == HOLD);
    assign data_o      = data_r;
    assign init_done_o = init_done_r;

`ifdef BSG_MEM_1RW_INIT_ASSERT_EN
    logic                     pend_r;
    logic                     pend_w_r;
    logic [addr_width_lp-1:0] pend_addr_r;
    logic [width_p-1:0]       pend_data_r, pend_mask_r;

    always_ff @(negedge clk_i) begin
        if (reset_n_i) begin
            if (yumi_i && !v_o)
                $error("%m: yumi_i asserted while v_o is low");
            if (v_i && ready_o && !mem_valid)
                $error("%m: request accepted with out-of-range address %0d", addr_i);
            if (pend_r && (!v_i || w_i !== pend_w_r || addr_i !== pend_addr_r
                           || data_i !== pend_data_r || w_mask_i !== pend_mask_r))
                $error("%m: pending request dropped or changed before acceptance");
            if (init_done_r && ($isunknown(v_i) || $isunknown(yumi_i)))
                $error("%m: X on v_i or yumi_i after init");
            pend_r      <= v_i & ~ready_o & (state_r != INIT);
            pend_w_r    <= w_i;
            pend_addr_r <= addr_i;
            pend_data_r <= data_i;
            pend_mask_r <= w_mask_i;
        end else begin
            pend_r <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_init.sv
// Directed bench for bsg_mem_1rw_sync_mask_write_bit_init with width_p=8, els_p=6, init_val_p=8'hA5.
module tb_bsg_mem_1rw_sync_mask_write_bit_init;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       v_i = 1'b0, w_i = 1'b0, yumi_i = 1'b0;
    logic [2:0] addr_i = '0;
    logic [7:0] data_i = '0, w_mask_i = '0;
    logic       ready_o, v_o, init_done_o;
    logic [7:0] data_o;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    bsg_mem_1rw_sync_mask_write_bit_init #(
        .width_p    (8),
        .els_p      (6),
        .init_val_p (8'hA5)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .w_i         (w_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .w_mask_i    (w_mask_i),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .init_done_o (init_done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] a,
                         input logic [7:0] d, input logic [7:0] m, input logic y);
        v_i = v; w_i = w; addr_i = a; data_i = d; w_mask_i = m; yumi_i = y;
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        tick(); tick();
        vec++; if (ready_o !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        vec++; if (v_o !== 1'b0) begin errs++; $display("FAIL reset_v_o: got %b want 0", v_o); end
        vec++; if (init_done_o !== 1'b0) begin errs++; $display("FAIL reset_init_done: got %b want 0", init_done_o); end
        vec++; if (data_o !== 8'h00) begin errs++; $display("FAIL reset_data_o: got %h want 00", data_o); end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vec++; if (ready_o !== 1'b0 || init_done_o !== 1'b0) begin
                errs++; $display("FAIL sweep_cycle%0d: ready=%b init_done=%b want 0,0", i, ready_o, init_done_o);
            end
            tick();
        end
        vec++; if (ready_o !== 1'b1 || init_done_o !== 1'b1) begin
            errs++; $display("FAIL sweep_end: ready=%b init_done=%b want 1,1", ready_o, init_done_o);
        end
    endtask

    task automatic test_init_reads();
        for (int a = 0; a < 6; a++) begin
            drive(1, 0, 3'(a), 0, 0, a != 0);
            tick();
            vec++; if (v_o !== 1'b1 || data_o !== 8'hA5) begin
                errs++; $display("FAIL init_read%0d: v_o=%b data=%h want 1,a5", a, v_o, data_o);
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        vec++; if (v_o !== 1'b0) begin errs++; $display("FAIL init_read_release: v_o=%b want 0", v_o); end
    endtask

    task automatic test_write_mask();
        drive(1, 1, 2, 8'hFF, 8'h0F, 0);
        vec++; if (ready_o !== 1'b1) begin errs++; $display("FAIL wr_ready: got %b want 1", ready_o); end
        tick();
        vec++; if (v_o !== 1'b0) begin errs++; $display("FAIL wr_no_resp: v_o=%b want 0", v_o); end
        drive(1, 0, 2, 0, 0, 0);
        tick();
        vec++; if (v_o !== 1'b1 || data_o !== 8'hAF) begin
            errs++; $display("FAIL raw_read: v_o=%b data=%h want 1,af", v_o, data_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        vec++; if (v_o !== 1'b0) begin errs++; $display("FAIL raw_release: v_o=%b want 0", v_o); end
    endtask

    task automatic test_hold();
        drive(1, 0, 3, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            vec++; if (v_o !== 1'b1 || data_o !== 8'hA5 || ready_o !== 1'b0) begin
                errs++; $display("FAIL hold_cycle%0d: v_o=%b data=%h ready=%b want 1,a5,0", i, v_o, data_o, ready_o);
            end
            tick();
        end
        drive(1, 0, 2, 0, 0, 1);
        vec++; if (ready_o !== 1'b1) begin errs++; $display("FAIL hold_yumi_ready: got %b want 1", ready_o); end
        tick();
        vec++; if (v_o !== 1'b1 || data_o !== 8'hAF) begin
            errs++; $display("FAIL hold_reread: v_o=%b data=%h want 1,af", v_o, data_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        vec++; if (v_o !== 1'b0) begin errs++; $display("FAIL hold_release: v_o=%b want 0", v_o); end
    endtask

    task automatic test_out_of_range();
        drive(1, 1, 7, 8'h00, 8'hFF, 0);
        vec++; if (ready_o !== 1'b1) begin errs++; $display("FAIL oor_wr_ready: got %b want 1", ready_o); end
        tick();
        drive(1, 0, 7, 0, 0, 0);
        tick();
        vec++; if (v_o !== 1'b1 || data_o !== 8'hA5) begin
            errs++; $display("FAIL oor_read7: v_o=%b data=%h want 1,a5", v_o, data_o);
        end
        drive(1, 0, 5, 0, 0, 1);
        tick();
        vec++; if (v_o !== 1'b1 || data_o !== 8'hA5) begin
            errs++; $display("FAIL oor_read5: v_o=%b data=%h want 1,a5", v_o, data_o);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_mask_zero();
        drive(1, 1, 4, 8'h5A, 8'h00, 0);
        tick();
        drive(1, 0, 4, 0, 0, 0);
        tick();
        vec++; if (data_o !== 8'hA5) begin errs++; $display("FAIL mask_zero: data=%h want a5", data_o); end
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_midsweep_reset();
        drive(1, 1, 0, 8'h3C, 8'hFF, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        tick();
        vec++; if (data_o !== 8'h3C) begin errs++; $display("FAIL pre_reset_read: data=%h want 3c", data_o); end
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        vec++; if (v_o !== 1'b0 || data_o !== 8'h00 || ready_o !== 1'b0 || init_done_o !== 1'b0) begin
            errs++; $display("FAIL async_clear: v_o=%b data=%h ready=%b init_done=%b want 0,00,0,0",
                             v_o, data_o, ready_o, init_done_o);
        end
        tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        vec++; if (ready_o !== 1'b0 || init_done_o !== 1'b0) begin
            errs++; $display("FAIL midsweep_clear: ready=%b init_done=%b want 0,0", ready_o, init_done_o);
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vec++; if (ready_o !== 1'b0) begin errs++; $display("FAIL resweep_cycle%0d: ready=%b want 0", i, ready_o); end
            tick();
        end
        vec++; if (ready_o !== 1'b1 || init_done_o !== 1'b1) begin
            errs++; $display("FAIL resweep_end: ready=%b init_done=%b want 1,1", ready_o, init_done_o);
        end
        drive(1, 0, 0, 0, 0, 0);
        tick();
        vec++; if (data_o !== 8'hA5) begin errs++; $display("FAIL resweep_addr0: data=%h want a5", data_o); end
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 3'(i), 8'(8'h10 + 8'h11 * i), 8'hFF, 0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 3'(i), 0, 0, i != 0);
            tick();
            exp = 8'(8'h10 + 8'h11 * i);
            vec++; if (v_o !== 1'b1 || data_o !== exp) begin
                errs++; $display("FAIL b2b_read%0d: v_o=%b data=%h want 1,%h", i, v_o, data_o, exp);
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        vec++; if (v_o !== 1'b0) begin errs++; $display("FAIL b2b_release: v_o=%b want 0", v_o); end
    endtask

    initial begin
        test_reset();
        test_init_reads();
        test_write_mask();
        test_hold();
        test_out_of_range();
        test_mask_zero();
        test_midsweep_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/bsg_mem_1rw_sync_mask_write_bit_init.md
Name: bsg_mem_1rw_sync_mask_write_bit_init

Overview:
- Parametrised single-port synchronous RAM with per-bit write mask.
- Adds a hardware init sweep after reset and a valid/ready request side.
- Adds a valid/yumi response side with a held output register.
- Sits between cache/tag controllers and the raw 1rw bit-mask macro; guarantees known contents without software init and never drops read data under back-pressure.

Parameters:
- width_p, 8, data and mask width in bits (>=1)
- els_p, 16, number of words (>=2; need not be a power of two)
- init_val_p, 0, value written to every word during the init sweep (width_p bits)
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived; do not override)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  request valid
- ready_o  out  1  request accepted when v_i & ready_o
- w_i  in  1  1 = write, 0 = read
- addr_i  in  addr_width_lp  word address
- data_i  in  width_p  write data
- w_mask_i  in  width_p  per-bit write enable; 1 = bit written
- v_o  out  1  read data valid
- data_o  out  width_p  read data, held while v_o & !yumi_i
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o
- init_done_o  out  1  init sweep complete

Behaviour:
- Reset:
  - Asynchronous assertion on reset_n_i low; synchronous release on clk_i.
  - During reset: state = INIT, init counter = 0, ready_o = 0, v_o = 0, init_done_o = 0, data_o = 0.
- States: INIT, RUN, HOLD.
- INIT:
  - Each cycle writes init_val_p with full mask to address cnt; cnt increments by 1.
  - After writing address els_p-1, go to RUN; init_done_o = 1 from the next cycle.
  - Sweep takes exactly els_p cycles after reset release.
  - ready_o = 0 throughout; v_i is ignored.
  - Reset asserted mid-sweep restarts from address 0.
- RUN:
  - ready_o = 1.
  - Write handshake: mem[addr] = (mem[addr] & ~w_mask_i) | (data_i & w_mask_i). Takes effect at the clock edge. No response and v_o is unaffected.
  - Read handshake: data is captured into the output register one cycle later, v_o = 1 in that cycle (latency 1), then go to HOLD.
  - Back-to-back reads are allowed: a read accepted in cycle N with yumi_i in cycle N+1 lets a new read be accepted in cycle N+1.
- HOLD:
  - v_o = 1; data_o stable.
  - ready_o = yumi_i (combinational pass-through).
  - yumi_i without a new read: go to RUN, v_o = 0 next cycle.
  - yumi_i with a read accepted the same cycle: stay in HOLD, new data next cycle.
  - No yumi_i: stay, ready_o = 0.
- Read-after-write: a read of an address written in the previous accepted cycle returns the new value. Masked-off bits keep the old value.
- Out-of-range address (addr_i >= els_p, when els_p is not a power of two):
  - The handshake completes normally.
  - Writes are dropped.
  - Reads return init_val_p.
- w_mask_i = 0 write: handshake completes, memory unchanged.
- v_i low: no memory access; the memory enable is deasserted for power.
- init_done_o stays 1 until the next reset.

Optional Feature:
- Macro: BSG_MEM_1RW_INIT_ASSERT_EN.
- Defined: simulation-only checks, evaluated on negedge clk_i, each reporting an $error naming the instance:
  - yumi_i = 1 while v_o = 0
  - v_i & ready_o with addr_i >= els_p
  - v_i deasserted or request fields changed while v_i & !ready_o in RUN/HOLD (request must be held until accepted)
  - any X on v_i or yumi_i after init_done_o
- Undefined: no checks compiled. Functional behaviour is identical in both cases.

Test Plan (width_p=8, els_p=6, init_val_p=8'hA5):
- Release reset, v_i=0 -> ready_o=0 for exactly 6 cycles, init_done_o=1 on cycle 7; reads of addresses 0..5 all return 8'hA5.
- Write addr 2, data 8'hFF, mask 8'h0F; then read addr 2 with yumi_i held 1 -> data_o=8'hAF, v_o=1 exactly 1 cycle after accept.
- Read addr 3 with yumi_i=0 for 4 cycles -> v_o=1 and data_o=8'hA5 stable, ready_o=0 throughout; yumi_i=1 with a same-cycle read of addr 2 -> 8'hAF next cycle.
- Write addr 7 (out of range) data 8'h00 mask 8'hFF, then read addr 7 and addr 5 -> both return 8'hA5.
- Assert reset_n_i for 1 cycle midway through the sweep (cycle 3) -> outputs clear immediately; sweep restarts and takes 6 full cycles after release.
- Stream of 6 back-to-back reads (addr 0..5) with yumi_i=1 every cycle -> 6 consecutive v_o cycles, data in order, no bubbles.
